// File: rtl/cu_decode_mem_ctrl.sv
// rtl/cu_decode_mem_ctrl.sv - ARM-subset control: ID decode with bubble mux, EX/MEM control register
//
// Ports:
//   clk                  pipeline clock, rising edge
//   R                    asynchronous active-high reset of the EX/MEM register
//   instruction[31:0]    instruction from IF/ID
//   S                    bubble select (1 forces every ID_* output to 0)
//   ID_*                 decoded control signals for the ID stage (combinational)
//   in_EX_*              EX-stage memory/writeback control bits
//   MEM_*                registered MEM-stage copies of in_EX_*
module cu_decode_mem_ctrl (
  input  logic        clk,
  input  logic        R,
  input  logic [31:0] instruction,
  input  logic        S,
  output logic [3:0]  ID_opcode,
  output logic        ID_AM,
  output logic        ID_S_enable,
  output logic        ID_load_instr,
  output logic        ID_RF_enable,
  output logic        ID_Size_enable,
  output logic        ID_RW_enable,
  output logic        ID_Enable_signal,
  output logic        ID_BL_instr,
  output logic        ID_B_instr,
  input  logic        in_EX_load_instr,
  input  logic        in_EX_RF_enable,
  input  logic        in_EX_Size_enable,
  input  logic        in_EX_RW_enable,
  input  logic        in_EX_Enable_signal,
  output logic        MEM_load_instr,
  output logic        MEM_RF_enable,
  output logic        MEM_Size_enable,
  output logic        MEM_RW_enable,
  output logic        MEM_Enable_signal
);

  logic [3:0] d_opcode;
  logic       d_am;
  logic       d_s_enable;
  logic       d_load_instr;
  logic       d_rf_enable;
  logic       d_size_enable;
  logic       d_rw_enable;
  logic       d_enable_signal;
  logic       d_bl_instr;
  logic       d_b_instr;

  // The condition field is resolved elsewhere in the pipeline.
  logic unused_cond;
  assign unused_cond = ^instruction[31:28];

  always_comb begin
    d_opcode        = 4'b0000;
    d_am            = 1'b0;
    d_s_enable      = 1'b0;
    d_load_instr    = 1'b0;
    d_rf_enable     = 1'b0;
    d_size_enable   = 1'b0;
    d_rw_enable     = 1'b0;
    d_enable_signal = 1'b0;
    d_bl_instr      = 1'b0;
    d_b_instr       = 1'b0;

    // An all-zero word is the pipeline NOP, even though it would otherwise
    // look like a data-processing AND.
    if (instruction != 32'h0) begin
      if (instruction[27:26] == 2'b00) begin
        d_opcode    = instruction[24:21];
        d_s_enable  = instruction[20];
        d_am        = instruction[25];
        // TST/TEQ/CMP/CMN (1000..1011) only set flags.
        d_rf_enable = (instruction[24:23] != 2'b10);
      end else if (instruction[27:26] == 2'b01) begin
        // U selects add (0100) or subtract (0010) for the address offset.
        d_opcode        = instruction[23] ? 4'b0100 : 4'b0010;
        d_am            = ~instruction[25];
        d_load_instr    = instruction[20];
        d_rf_enable     = instruction[20];
        d_rw_enable     = ~instruction[20];
        d_size_enable   = instruction[22];
        d_enable_signal = 1'b1;
      end else if (instruction[27:25] == 3'b101) begin
        d_b_instr   = 1'b1;
        d_bl_instr  = instruction[24];
        d_rf_enable = instruction[24];
      end
    end
  end

  // Bubble mux: a stall inserts a NOP into the ID/EX boundary.
  assign ID_opcode        = S ? 4'b0000 : d_opcode;
  assign ID_AM            = S ? 1'b0 : d_am;
  assign ID_S_enable      = S ? 1'b0 : d_s_enable;
  assign ID_load_instr    = S ? 1'b0 : d_load_instr;
  assign ID_RF_enable     = S ? 1'b0 : d_rf_enable;
  assign ID_Size_enable   = S ? 1'b0 : d_size_enable;
  assign ID_RW_enable     = S ? 1'b0 : d_rw_enable;
  assign ID_Enable_signal = S ? 1'b0 : d_enable_signal;
  assign ID_BL_instr      = S ? 1'b0 : d_bl_instr;
  assign ID_B_instr       = S ? 1'b0 : d_b_instr;

  // EX/MEM register loads every cycle; there is no stall path at this boundary.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      MEM_load_instr    <= 1'b0;
      MEM_RF_enable     <= 1'b0;
      MEM_Size_enable   <= 1'b0;
      MEM_RW_enable     <= 1'b0;
      MEM_Enable_signal <= 1'b0;
    end else begin
      MEM_load_instr    <= in_EX_load_instr;
      MEM_RF_enable     <= in_EX_RF_enable;
      MEM_Size_enable   <= in_EX_Size_enable;
      MEM_RW_enable     <= in_EX_RW_enable;
      MEM_Enable_signal <= in_EX_Enable_signal;
    end
  end

endmodule

// File: tb/tb_cu_decode_mem_ctrl.sv
// tb/tb_cu_decode_mem_ctrl.sv - scoreboard bench for cu_decode_mem_ctrl
module tb_cu_decode_mem_ctrl;

  logic        clk = 1'b0;
  logic        R;
  logic [31:0] instruction;
  logic        S;
  logic [3:0]  ID_opcode;
  logic        ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable;
  logic        ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr;
  logic        in_EX_load_instr, in_EX_RF_enable, in_EX_Size_enable;
  logic        in_EX_RW_enable, in_EX_Enable_signal;
  logic        MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable, MEM_Enable_signal;

  int checks = 0;
  int errors = 0;

  logic [12:0] id_q[$];
  logic [4:0]  mem_q[$];

  always #5 clk = ~clk;

  cu_decode_mem_ctrl dut (
    .clk                 (clk),
    .R                   (R),
    .instruction         (instruction),
    .S                   (S),
    .ID_opcode           (ID_opcode),
    .ID_AM               (ID_AM),
    .ID_S_enable         (ID_S_enable),
    .ID_load_instr       (ID_load_instr),
    .ID_RF_enable        (ID_RF_enable),
    .ID_Size_enable      (ID_Size_enable),
    .ID_RW_enable        (ID_RW_enable),
    .ID_Enable_signal    (ID_Enable_signal),
    .ID_BL_instr         (ID_BL_instr),
    .ID_B_instr          (ID_B_instr),
    .in_EX_load_instr    (in_EX_load_instr),
    .in_EX_RF_enable     (in_EX_RF_enable),
    .in_EX_Size_enable   (in_EX_Size_enable),
    .in_EX_RW_enable     (in_EX_RW_enable),
    .in_EX_Enable_signal (in_EX_Enable_signal),
    .MEM_load_instr      (MEM_load_instr),
    .MEM_RF_enable       (MEM_RF_enable),
    .MEM_Size_enable     (MEM_Size_enable),
    .MEM_RW_enable       (MEM_RW_enable),
    .MEM_Enable_signal   (MEM_Enable_signal)
  );

  wire [12:0] id_vec  = {ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable,
                         ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr};
  wire [4:0]  mem_vec = {MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable, MEM_Enable_signal};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Expected ID vector: {opcode, AM, S, load, RF, Size, RW, Enable, BL, B}
  function automatic logic [12:0] idv(input logic [3:0] op, input logic am, input logic s,
                                      input logic ld, input logic rf, input logic sz,
                                      input logic rw, input logic en, input logic bl,
                                      input logic b);
    return {op, am, s, ld, rf, sz, rw, en, bl, b};
  endfunction

  task automatic drive_id(input string tag, input logic [31:0] instr, input logic s,
                          input logic [12:0] exp);
    logic [12:0] e;
    instruction = instr;
    S = s;
    id_q.push_back(exp);
    #1;
    if (id_q.size() == 0) check({tag, "_q_empty"}, 32'd1, 32'd0);
    else begin
      e = id_q.pop_front();
      check(tag, {19'd0, id_vec}, {19'd0, e});
    end
  endtask

  task automatic drive_ex(input logic [4:0] v);
    {in_EX_load_instr, in_EX_RF_enable, in_EX_Size_enable, in_EX_RW_enable, in_EX_Enable_signal} = v;
    mem_q.push_back(v);
  endtask

  task automatic mem_edge(input string tag);
    logic [4:0] e;
    @(posedge clk);
    #1;
    if (mem_q.size() == 0) check({tag, "_q_empty"}, 32'd1, 32'd0);
    else begin
      e = mem_q.pop_front();
      check(tag, {27'd0, mem_vec}, {27'd0, e});
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [12:0] exp;
  } id_case_t;

  id_case_t cases[$];
  logic [4:0] rv;
  logic [4:0] prev;

  initial begin
    R = 1'b1;
    S = 1'b0;
    instruction = 32'h0;
    {in_EX_load_instr, in_EX_RF_enable, in_EX_Size_enable, in_EX_RW_enable, in_EX_Enable_signal} = 5'b11111;

    // Reset holds MEM outputs at 0 across clock edges, whatever the inputs.
    #1;
    check("mem_reset_initial", {27'd0, mem_vec}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mem_reset_held", {27'd0, mem_vec}, 32'd0);

    cases.push_back('{32'hE2921001, idv(4'b0100, 1, 1, 0, 1, 0, 0, 0, 0, 0)}); // ADDS imm
    cases.push_back('{32'h02921001, idv(4'b0100, 1, 1, 0, 1, 0, 0, 0, 0, 0)}); // cond ignored
    cases.push_back('{32'hE1510002, idv(4'b1010, 0, 1, 0, 0, 0, 0, 0, 0, 0)}); // CMP
    cases.push_back('{32'hE1100002, idv(4'b1000, 0, 1, 0, 0, 0, 0, 0, 0, 0)}); // TST
    cases.push_back('{32'hE1700002, idv(4'b1011, 0, 1, 0, 0, 0, 0, 0, 0, 0)}); // CMN
    cases.push_back('{32'hE0E00002, idv(4'b0111, 0, 0, 0, 1, 0, 0, 0, 0, 0)}); // RSC
    cases.push_back('{32'hE1800002, idv(4'b1100, 0, 0, 0, 1, 0, 0, 0, 0, 0)}); // ORR
    cases.push_back('{32'hE5D21004, idv(4'b0100, 1, 0, 1, 1, 1, 0, 1, 0, 0)}); // LDRB imm
    cases.push_back('{32'hE5021004, idv(4'b0010, 1, 0, 0, 0, 0, 1, 1, 0, 0)}); // STR imm -4
    cases.push_back('{32'hE7921003, idv(4'b0100, 0, 0, 1, 1, 0, 0, 1, 0, 0)}); // LDR reg
    cases.push_back('{32'hEB000002, idv(4'b0000, 0, 0, 0, 1, 0, 0, 0, 1, 1)}); // BL
    cases.push_back('{32'hEA000002, idv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1)}); // B
    cases.push_back('{32'h00000000, idv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0)}); // NOP
    cases.push_back('{32'hE8000000, idv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0)}); // other

    // ID path while R is still asserted: reset must not touch it.
    foreach (cases[i]) begin
      drive_id($sformatf("id_dec_%0d", i), cases[i].instr, 1'b0, cases[i].exp);
      drive_id($sformatf("id_bubble_%0d", i), cases[i].instr, 1'b1, 13'd0);
      drive_id($sformatf("id_restore_%0d", i), cases[i].instr, 1'b0, cases[i].exp);
    end

    // Release reset away from an edge; outputs wait for the next rising edge.
    @(negedge clk);
    R = 1'b0;
    drive_ex(5'b11000);
    #1;
    check("mem_hold_after_release", {27'd0, mem_vec}, 32'd0);
    mem_edge("mem_first_load");

    drive_ex(5'b00111);
    #1;
    check("mem_hold_pre_edge", {27'd0, mem_vec}, {27'd0, 5'b11000});
    mem_edge("mem_second_load");

    for (int k = 0; k < 8; k++) begin
      rv = 5'($urandom);
      prev = mem_vec;
      drive_ex(rv);
      #1;
      check($sformatf("mem_rand_hold_%0d", k), {27'd0, mem_vec}, {27'd0, prev});
      mem_edge($sformatf("mem_rand_%0d", k));
    end

    // Asynchronous clear mid-cycle.
    drive_ex(5'b11111);
    mem_edge("mem_all_ones");
    @(negedge clk);
    R = 1'b1;
    #1;
    check("mem_async_clear", {27'd0, mem_vec}, 32'd0);
    @(posedge clk);
    #1;
    check("mem_clear_held", {27'd0, mem_vec}, 32'd0);
    check("mem_queue_drained", mem_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
